// File: rtl/n64_joybus_tx_if.sv
// Host-side bus of the Joybus transmitter: frame-buffer writes, frame start, and line/status outputs.
// The host uses the master modport and the transmitter uses the slave modport.
interface n64_joybus_tx_if #(
    parameter int DEPTH = 8
);
    logic                     wr_en;
    logic [7:0]               wr_data;
    logic                     start;
    logic                     stop_sel;
    logic                     data;
    logic                     data_oe;
    logic                     busy;
    logic                     done;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     wr_err;

    modport master (
        output wr_en, wr_data, start, stop_sel,
        input  data, data_oe, busy, done, count, full, wr_err
    );

    modport slave (
        input  wr_en, wr_data, start, stop_sel,
        output data, data_oe, busy, done, count, full, wr_err
    );
endinterface

// File: rtl/n64_joybus_tx.sv
// N64 Joybus single-wire transmitter: sends a queued frame of bytes MSB-first in 4U bit cells,
// then a 1U (console) or 2U (controller) stop bit.
module n64_joybus_tx #(
    parameter int CYC_PER_US = 50,
    parameter int DEPTH      = 8
) (
    input  logic            clk,
    input  logic            rst,
    n64_joybus_tx_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(3 * CYC_PER_US + 1);

    // Each phase counter load is one less than the phase length, because the counter counts down to 0.
    // A LOAD cycle already drives the line low, so the first low phase after it loads two less.
    localparam logic [PW-1:0] SHORT_M1 = PW'(CYC_PER_US - 1);
    localparam logic [PW-1:0] LONG_M1  = PW'(3 * CYC_PER_US - 1);
    localparam logic [PW-1:0] SHORT_M2 = PW'(CYC_PER_US - 2);
    localparam logic [PW-1:0] LONG_M2  = PW'(3 * CYC_PER_US - 2);
    localparam logic [PW-1:0] STOP2_M1 = PW'(2 * CYC_PER_US - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOW,
        S_HIGH,
        S_STOP
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [7:0]      shreg;
    logic [2:0]      bit_idx;
    logic [PW-1:0]   ph_cnt;
    logic            stop_sel_q;
    logic            done_q;
    logic            wr_err_q;

    logic            idle;
    logic            full;
    logic            wr_ok;
    logic            start_ok;
    logic            pop;
    logic            ph_zero;
    logic            line_low;

    assign idle     = (state == S_IDLE);
    assign full     = (count == CW'(DEPTH));
    assign wr_ok    = bus.wr_en && idle && !full;
    // A write in the same idle cycle as start counts toward the frame.
    assign start_ok = bus.start && idle && ((count != '0) || wr_ok);
    assign pop      = (state == S_LOAD);
    assign ph_zero  = (ph_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: a default assignment before the case keeps this combinational and avoids a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start_ok) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_LOW;
            S_LOW:  if (ph_zero) state_nxt = S_HIGH;
            S_HIGH: begin
                if (ph_zero) begin
                    if (bit_idx != 3'd0)    state_nxt = S_LOW;
                    else if (count != '0)   state_nxt = S_LOAD;
                    else                    state_nxt = S_STOP;
                end
            end
            S_STOP: if (ph_zero) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        line_low = 1'b0;
        if (state inside {S_LOAD, S_LOW, S_STOP}) line_low = 1'b1;
    end

    assign bus.data    = ~line_low;
    assign bus.data_oe = line_low;
    assign bus.busy    = ~idle;
    assign bus.done    = done_q;
    assign bus.count   = count;
    assign bus.full    = full;
    assign bus.wr_err  = wr_err_q;

    // NOTE: the byte storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            shreg      <= '0;
            bit_idx    <= '0;
            ph_cnt     <= '0;
            stop_sel_q <= 1'b0;
            done_q     <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            wr_err_q <= bus.wr_en && !wr_ok;
            done_q   <= (state == S_STOP) && ph_zero;
            count    <= count + CW'(wr_ok) - CW'(pop);
            if (wr_ok)    wr_ptr     <= wr_ptr + AW'(1);
            if (pop)      rd_ptr     <= rd_ptr + AW'(1);
            if (start_ok) stop_sel_q <= bus.stop_sel;

            unique case (state)
                S_LOAD: begin
                    shreg   <= mem[rd_ptr];
                    bit_idx <= 3'd7;
                    ph_cnt  <= mem[rd_ptr][7] ? SHORT_M2 : LONG_M2;
                end
                S_LOW: begin
                    if (ph_zero) ph_cnt <= shreg[7] ? LONG_M1 : SHORT_M1;
                    else         ph_cnt <= ph_cnt - PW'(1);
                end
                S_HIGH: begin
                    if (!ph_zero) begin
                        ph_cnt <= ph_cnt - PW'(1);
                    end else if (bit_idx != 3'd0) begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_idx <= bit_idx - 3'd1;
                        ph_cnt  <= shreg[6] ? SHORT_M1 : LONG_M1;
                    end else begin
                        // Harmless when another byte follows: LOAD reloads the counter.
                        ph_cnt <= stop_sel_q ? STOP2_M1 : SHORT_M1;
                    end
                end
                S_STOP: begin
                    if (!ph_zero) ph_cnt <= ph_cnt - PW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_n64_joybus_tx.sv
// Self-checking bench for n64_joybus_tx with U=4 cycles (16-cycle bit cells), DEPTH=8.
// Frame vectors come from a table; buffer limits, busy-time requests and mid-frame reset are hand sequences.
module tb_n64_joybus_tx;
    localparam int CYC_PER_US = 4;
    localparam int DEPTH      = 8;
    localparam int MAX_CYC    = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    n64_joybus_tx_if #(.DEPTH(DEPTH)) bus();

    n64_joybus_tx #(
        .CYC_PER_US(CYC_PER_US),
        .DEPTH     (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic       stop_sel;
        logic       same;      // last write shares its cycle with start
        int         exp_done;  // cycles from start acceptance to done
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Returns at the first negedge after start was sampled (k = 1).
    task automatic start_frame(input logic sel);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.stop_sel = sel;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(inout int k);
        while (bus.done !== 1'b1 && k < MAX_CYC) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] bytes [3];
        logic       wave [$];
        logic       exp_wave [$];
        int         runs [$];
        int         k, run, oe_bad, busy_bad, wave_bad, stop_len, idx;
        logic [7:0] dec;

        bytes[0] = v.b0;
        bytes[1] = v.b1;
        bytes[2] = v.b2;
        for (int i = 0; i < v.n; i++) begin
            @(negedge clk);
            bus.wr_en    = 1'b1;
            bus.wr_data  = bytes[i];
            bus.stop_sel = v.stop_sel;
            bus.start    = v.same && (i == v.n - 1);
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        if (!v.same) begin
            check("pre_count", 32'(bus.count), 32'(v.n));
            bus.start = 1'b1;
            @(negedge clk);
        end
        bus.start = 1'b0;

        k = 1;
        oe_bad = 0;
        busy_bad = 0;
        while (bus.done !== 1'b1 && k < MAX_CYC) begin
            wave.push_back(bus.data);
            if (bus.data_oe !== ~bus.data) oe_bad++;
            if (bus.busy !== 1'b1) busy_bad++;
            @(negedge clk);
            k++;
        end
        check("done_at", 32'(k), 32'(v.exp_done));
        check("busy_at_done", 32'(bus.busy), 32'(0));
        check("data_at_done", 32'(bus.data), 32'(1));
        check("count_at_done", 32'(bus.count), 32'(0));
        check("oe_inverse", 32'(oe_bad), 32'(0));
        check("busy_frame", 32'(busy_bad), 32'(0));

        for (int j = 0; j < v.n; j++) begin
            for (int b = 7; b >= 0; b--) begin
                for (int c = 0; c < 16; c++) exp_wave.push_back(c >= (bytes[j][b] ? 4 : 12));
            end
        end
        for (int c = 0; c < (v.stop_sel ? 8 : 4); c++) exp_wave.push_back(1'b0);
        wave_bad = (wave.size() == exp_wave.size()) ? 0 : 1;
        for (int i = 0; i < wave.size() && i < exp_wave.size(); i++) begin
            if (wave[i] !== exp_wave[i]) wave_bad++;
        end
        check("waveform", 32'(wave_bad), 32'(0));

        run = 0;
        foreach (wave[i]) begin
            if (wave[i] == 1'b0) begin
                run++;
            end else if (run > 0) begin
                runs.push_back(run);
                run = 0;
            end
        end
        if (run > 0) runs.push_back(run);
        check("low_pulses", 32'(runs.size()), 32'(8 * v.n + 1));
        for (int j = 0; j < v.n; j++) begin
            dec = 8'h00;
            for (int b = 0; b < 8; b++) begin
                idx = 8 * j + b;
                dec = {dec[6:0], (idx < runs.size()) ? (runs[idx] < 8) : 1'bx};
            end
            check("decoded_byte", 32'(dec), 32'(bytes[j]));
        end
        stop_len = (runs.size() > 0) ? runs[runs.size() - 1] : 0;
        check("stop_len", 32'(stop_len), v.stop_sel ? 32'd8 : 32'd4);

        @(negedge clk);
        check("done_pulse_1cyc", 32'(bus.done), 32'(0));
    endtask

    initial begin
        int k;
        int idle_bad;
        logic done_seen;

        bus.wr_en    = 1'b0;
        bus.wr_data  = 8'h00;
        bus.start    = 1'b0;
        bus.stop_sel = 1'b0;

        vecs[0] = '{n: 1, b0: 8'h00, b1: 8'h00, b2: 8'h00, stop_sel: 1'b0, same: 1'b0, exp_done: 133};
        vecs[1] = '{n: 2, b0: 8'hA5, b1: 8'hFF, b2: 8'h00, stop_sel: 1'b1, same: 1'b0, exp_done: 265};
        vecs[2] = '{n: 1, b0: 8'h80, b1: 8'h00, b2: 8'h00, stop_sel: 1'b0, same: 1'b1, exp_done: 133};
        vecs[3] = '{n: 2, b0: 8'h01, b1: 8'h7E, b2: 8'h00, stop_sel: 1'b0, same: 1'b0, exp_done: 261};
        vecs[4] = '{n: 3, b0: 8'h55, b1: 8'hC3, b2: 8'h3C, stop_sel: 1'b1, same: 1'b0, exp_done: 393};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_data", 32'(bus.data), 32'(1));
        check("rst_oe", 32'(bus.data_oe), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_wr_err", 32'(bus.wr_err), 32'(0));
        check("rst_count", 32'(bus.count), 32'(0));
        check("rst_full", 32'(bus.full), 32'(0));
        rst = 1'b0;

        // Start on an empty buffer is ignored without error
        start_frame(1'b0);
        check("empty_start_busy", 32'(bus.busy), 32'(0));
        check("empty_start_data", 32'(bus.data), 32'(1));
        check("empty_start_err", 32'(bus.wr_err), 32'(0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Nine writes into an 8-deep buffer
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 8) begin
                check("full_after_8", 32'(bus.full), 32'(1));
                check("count_after_8", 32'(bus.count), 32'(8));
            end
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(i);
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("ninth_wr_err", 32'(bus.wr_err), 32'(1));
        check("ninth_count", 32'(bus.count), 32'(8));
        @(negedge clk);
        check("wr_err_pulse", 32'(bus.wr_err), 32'(0));
        start_frame(1'b0);
        k = 1;
        wait_done(k);
        check("full_frame_done", 32'(k), 32'(1 + 8 * 128 + 4));
        check("full_frame_count", 32'(bus.count), 32'(0));
        check("full_frame_full", 32'(bus.full), 32'(0));

        // Write and start while busy
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h00;
        @(negedge clk);
        bus.wr_en = 1'b0;
        start_frame(1'b0);
        k = 1;
        repeat (29) begin
            @(negedge clk);
            k++;
        end
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h11;
        @(negedge clk);
        k++;
        bus.wr_en = 1'b0;
        check("busy_wr_err", 32'(bus.wr_err), 32'(1));
        check("busy_wr_count", 32'(bus.count), 32'(0));
        bus.start    = 1'b1;
        bus.stop_sel = 1'b1;
        @(negedge clk);
        k++;
        bus.start = 1'b0;
        wait_done(k);
        check("busy_start_done", 32'(k), 32'(133));
        idle_bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.data !== 1'b1) idle_bad++;
        end
        check("no_second_frame", 32'(idle_bad), 32'(0));

        // Asynchronous reset in the low phase of the second bit
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h00;
        @(negedge clk);
        bus.wr_en = 1'b0;
        start_frame(1'b0);
        repeat (20) @(negedge clk);
        check("pre_rst_data", 32'(bus.data), 32'(0));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_data", 32'(bus.data), 32'(1));
        check("mid_rst_oe", 32'(bus.data_oe), 32'(0));
        check("mid_rst_busy", 32'(bus.busy), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_count", 32'(bus.count), 32'(0));
        done_seen = 1'b0;
        idle_bad  = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen = 1'b1;
            if (bus.busy !== 1'b0) idle_bad++;
        end
        check("post_rst_no_done", 32'(done_seen), 32'(0));
        check("post_rst_idle", 32'(idle_bad), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
